relu_pool: RTL and testbench

RELU_POOL -- requirements
Module: relu_pool

---
 rtl/cnn_pkg.sv | 15 +
 rtl/bias_relu.sv | 17 +
 rtl/relu_pool.sv | 166 ++++++++++++++++
 tb/tb_relu_pool.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions.
// Datapath widths, ofmap limits and FSM encoding.
package cnn_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 18;
  localparam int MAX_W      = 28;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bias_relu.sv
// Bias add with optional ReLU clamp.
// Q16.16 two's-complement, wraps on overflow.
module bias_relu #(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] bias_i,
  input  logic                  relu_i,
  output logic [DATA_WIDTH-1:0] r_o
);

  logic [DATA_WIDTH-1:0] v;

  assign v   = data_i + bias_i;
  assign r_o = (relu_i && v[DATA_WIDTH-1]) ? '0 : v;

endmodule

// File: rtl/relu_pool.sv
// Bias/ReLU plus 2x2 max-pool over a raster stream.
// Pooled results are written straight to SRAM.
module relu_pool #(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cnn_pkg::ADDR_WIDTH,
  parameter int MAX_W      = cnn_pkg::MAX_W
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  start,
  input  logic [4:0]            cfg_w,
  input  logic [4:0]            cfg_h,
  input  logic [DATA_WIDTH-1:0] cfg_bias,
  input  logic                  cfg_relu,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int LB_N  = MAX_W / 2;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

  cnn_pkg::state_t state_q;

  logic [4:0]            w_q;
  logic [4:0]            h_q;
  logic [DATA_WIDTH-1:0] bias_q;
  logic                  relu_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [4:0]            col_q;
  logic [4:0]            row_q;
  logic [DATA_WIDTH-1:0] pair_q;
  logic [DATA_WIDTH-1:0] lb_q [LB_N];

  logic                  out_valid_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  accept;
  logic                  last_col;
  logic                  last_row;
  logic [DATA_WIDTH-1:0] r;
  logic [DATA_WIDTH-1:0] hmax;
  logic [DATA_WIDTH-1:0] lb_rd;
  logic [DATA_WIDTH-1:0] pmax;
  logic [LB_AW-1:0]      lb_idx;
  logic                  lb_ok;
  logic [7:0]            prod;
  logic [ADDR_WIDTH-1:0] addr_d;

  assign accept   = in_valid && (state_q == cnn_pkg::S_RUN);
  assign last_col = (col_q == w_q - 5'd1);
  assign last_row = (row_q == h_q - 5'd1);

  bias_relu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bias_relu (
    .data_i(in_data),
    .bias_i(bias_q),
    .relu_i(relu_q),
    .r_o   (r)
  );

  assign hmax = ($signed(pair_q) > $signed(r)) ? pair_q : r;

  // Widths beyond MAX_W would index past the line buffer.
  assign lb_idx = LB_AW'(col_q >> 1);
  assign lb_ok  = (32'(lb_idx) < LB_N);
  assign lb_rd  = lb_ok ? lb_q[lb_idx] : '0;
  assign pmax   = ($signed(lb_rd) > $signed(hmax)) ? lb_rd : hmax;

  assign prod   = {4'd0, row_q[4:1]} * {4'd0, w_q[4:1]};
  assign addr_d = base_q + ADDR_WIDTH'(prod) + ADDR_WIDTH'(col_q[4:1]);

  // Even-column result waits here for its odd partner.
  always_ff @(posedge clk) begin
    if (accept && !col_q[0]) begin
      pair_q <= r;
    end
  end

  // Even rows park their horizontal max for the odd row below.
  always_ff @(posedge clk) begin
    if (accept && !row_q[0] && col_q[0] && lb_ok) begin
      lb_q[lb_idx] <= hmax;
    end
  end

  // Channel FSM, raster counters and registered SRAM write port.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q     <= cnn_pkg::S_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      base_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        cnn_pkg::S_IDLE: begin
          if (start) begin
            w_q     <= cfg_w;
            h_q     <= cfg_h;
            bias_q  <= cfg_bias;
            relu_q  <= cfg_relu;
            base_q  <= cfg_base;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= cnn_pkg::S_RUN;
          end
        end
        cnn_pkg::S_RUN: begin
          if (accept) begin
            if (row_q[0] && col_q[0]) begin
              out_valid_q <= 1'b1;
              out_addr_q  <= addr_d;
              out_data_q  <= pmax;
            end
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= cnn_pkg::S_DONE;
              end else begin
                row_q <= row_q + 5'd1;
              end
            end else begin
              col_q <= col_q + 5'd1;
            end
          end
        end
        cnn_pkg::S_DONE: begin
          state_q <= cnn_pkg::S_IDLE;
        end
        default: begin
          state_q <= cnn_pkg::S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_relu_pool.sv
// Directed bench for relu_pool.
// Expected SRAM writes are queued at stimulus time.
module tb_relu_pool;

  typedef struct packed {
    logic [17:0] a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        srstn = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  cfg_w = '0;
  logic [4:0]  cfg_h = '0;
  logic [31:0] cfg_bias = '0;
  logic        cfg_relu = 1'b0;
  logic [17:0] cfg_base = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic [17:0] out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] din [0:63];
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int          done_ref;

  relu_pool dut (
    .clk      (clk),
    .srstn    (srstn),
    .start    (start),
    .cfg_w    (cfg_w),
    .cfg_h    (cfg_h),
    .cfg_bias (cfg_bias),
    .cfg_relu (cfg_relu),
    .cfg_base (cfg_base),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_addr (out_addr),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mx(logic [31:0] a, logic [31:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Scoreboard consumer: every write strobe pops one expectation.
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 64'(out_addr), 64'(mon_e.a));
        chk("wr_data", 64'(out_data), 64'(mon_e.d));
      end
    end
  end

  task automatic model(int w, int h, logic [31:0] bias, bit relu,
                       logic [17:0] base);
    logic [31:0] r [0:63];
    logic [31:0] v;
    logic [31:0] m;
    exp_t        e;
    int          p;
    for (int i = 0; i < w * h; i++) begin
      v = din[i] + bias;
      r[i] = (relu && v[31]) ? 32'd0 : v;
    end
    for (int rr = 0; rr < h / 2; rr++) begin
      for (int cc = 0; cc < w / 2; cc++) begin
        p = 2 * rr * w + 2 * cc;
        m = mx(mx(r[p], r[p + 1]), mx(r[p + w], r[p + w + 1]));
        e.a = base + 18'(rr * (w / 2) + cc);
        e.d = m;
        sb.push_back(e);
      end
    end
  endtask

  task automatic begin_ch(int w, int h, logic [31:0] bias, bit relu,
                          logic [17:0] base);
    model(w, h, bias, relu, base);
    @(posedge clk); #1;
    start    = 1'b1;
    cfg_w    = 5'(w);
    cfg_h    = 5'(h);
    cfg_bias = bias;
    cfg_relu = relu;
    cfg_base = base;
    @(posedge clk); #1;
    start    = 1'b0;
    cfg_bias = 32'hDEAD_BEEF;
    cfg_base = 18'h3_FFFF;
  endtask

  task automatic send(logic [31:0] d, int gap);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'h5A5A_5A5A;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic end_ch(string tag);
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    chk({tag, "_all_writes"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic run_ch(string tag, int w, int h, logic [31:0] bias,
                        bit relu, logic [17:0] base, int gmax);
    begin_ch(w, h, bias, relu, base);
    @(negedge clk);
    chk({tag, "_busy_on"}, 64'(busy), 64'd1);
    for (int i = 0; i < w * h; i++) begin
      send(din[i], (i == w * h - 1) ? 0 : $urandom_range(0, gmax));
    end
    end_ch(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    srstn = 1'b1;

    // 4x4 ramp: 5, 7, 13, 15 at 0x100..0x103
    for (int i = 0; i < 16; i++) din[i] = 32'(i) << 16;
    run_ch("ramp4x4", 4, 4, 32'd0, 1'b1, 18'h100, 0);

    // all negative through ReLU, then without
    for (int i = 0; i < 4; i++) din[i] = 32'hFFFF_0000;
    run_ch("neg_relu", 2, 2, 32'd0, 1'b1, 18'h010, 0);
    run_ch("neg_pass", 2, 2, 32'd0, 1'b0, 18'h011, 0);

    // bias overflow wraps negative
    for (int i = 0; i < 4; i++) din[i] = 32'd1;
    run_ch("wrap_pass", 2, 2, 32'h7FFF_FFFF, 1'b0, 18'h020, 0);
    run_ch("wrap_relu", 2, 2, 32'h7FFF_FFFF, 1'b1, 18'h021, 0);

    // odd 5x3 with random gaps
    for (int i = 0; i < 15; i++) din[i] = $urandom;
    run_ch("odd5x3", 5, 3, $urandom, 1'b1, 18'h200, 3);

    // random 6x6 with signed mix, full rate
    for (int i = 0; i < 36; i++) din[i] = $urandom;
    run_ch("rand6x6", 6, 6, 32'h0001_0000, 1'b0, 18'h3_FFFE, 0);

    // abort mid-channel after 6 samples
    for (int i = 0; i < 16; i++) din[i] = $urandom;
    begin_ch(4, 4, 32'd0, 1'b0, 18'h040);
    for (int i = 0; i < 6; i++) send(din[i], 0);
    srstn = 1'b0;
    @(posedge clk); #1;
    srstn = 1'b1;
    sb.delete();
    done_ref = done_seen;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_addr", 64'(out_addr), 64'd0);
    chk("abort_out_data", 64'(out_data), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);

    // in_valid while idle must be ignored
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) send($urandom, 0);
    repeat (3) @(negedge clk);
    chk("idle_no_done", 64'(done_seen), 64'(done_ref));
    chk("idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 16; i++) din[i] = $urandom;
    run_ch("post_abort", 4, 4, 32'd0, 1'b1, 18'h080, 1);

    // start pulsed while running is ignored
    for (int i = 0; i < 4; i++) din[i] = 32'(i * 3) << 16;
    begin_ch(2, 2, 32'd0, 1'b0, 18'h0C0);
    send(din[0], 0);
    send(din[1], 0);
    start    = 1'b1;
    cfg_w    = 5'd4;
    cfg_h    = 5'd4;
    cfg_bias = 32'h0100_0000;
    cfg_base = 18'h1000;
    @(posedge clk); #1;
    start = 1'b0;
    send(din[2], 0);
    send(din[3], 0);
    end_ch("start_in_run");

    repeat (4) @(negedge clk);
    chk("final_queue", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
